// File: rtl/seven_seg_rx.sv
// Receiver for the multiplexed two-digit seven-segment bus: synchronise, filter, decode, reassemble.
// Build option: define SEVEN_SEG_RX_BCD_ONLY_EN to reject hex digits A-F.
module seven_seg_rx #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       digit_err,
    output logic       rx_busy
);

    localparam int SCNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SCNT_W-1:0] STABLE_MAX   = SCNT_W'(STABLE_CYCLES);
    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] GOT_MSB = 1'b1;

    // Returns {valid, nibble} for an active-low segment field.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg_n);
        logic [6:0] seg;
        seg        = ~seg_n;
        decode_seg = 5'h00;
        case (seg)
            7'h3F: decode_seg = 5'h10;
            7'h06: decode_seg = 5'h11;
            7'h5B: decode_seg = 5'h12;
            7'h4F: decode_seg = 5'h13;
            7'h66: decode_seg = 5'h14;
            7'h6D: decode_seg = 5'h15;
            7'h7D: decode_seg = 5'h16;
            7'h07: decode_seg = 5'h17;
            7'h7F: decode_seg = 5'h18;
            7'h6F: decode_seg = 5'h19;
`ifdef SEVEN_SEG_RX_BCD_ONLY_EN
`else
            7'h77: decode_seg = 5'h1A;
            7'h7C: decode_seg = 5'h1B;
            7'h39: decode_seg = 5'h1C;
            7'h5E: decode_seg = 5'h1D;
            7'h79: decode_seg = 5'h1E;
            7'h71: decode_seg = 5'h1F;
`endif
            default: decode_seg = 5'h00;
        endcase
    endfunction

    logic [7:0]        seg_p0;
    logic [7:0]        seg_p1;
    logic [7:0]        seg_p2;
    logic [SCNT_W-1:0] stab_cnt;
    logic [SCNT_W-1:0] stab_cnt_nxt;
    logic              seg_changed;
    logic              vld_p1;
    logic [4:0]        dec_p1;
    logic              sel_p1;

    logic [0:0]        state;
    logic [3:0]        msb_nib;
    logic [TCNT_W-1:0] tmo_cnt;

    // Stage p0/p1: two-flop synchroniser; p2 holds the previous synchronised word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0   <= 8'h7F;
            seg_p1   <= 8'h7F;
            seg_p2   <= 8'h7F;
            stab_cnt <= '0;
        end else begin
            seg_p0   <= seg_in;
            seg_p1   <= seg_p0;
            seg_p2   <= seg_p1;
            stab_cnt <= stab_cnt_nxt;
        end
    end

    always_comb begin
        seg_changed  = (seg_p1 != seg_p2);
        stab_cnt_nxt = stab_cnt;
        if (seg_changed) begin
            stab_cnt_nxt = SCNT_W'(1);
        end else if (stab_cnt != STABLE_MAX) begin
            stab_cnt_nxt = stab_cnt + SCNT_W'(1);
        end
        // Fires only on the transition into saturation, so each stable run accepts once.
        vld_p1 = (stab_cnt_nxt == STABLE_MAX) && ((stab_cnt != STABLE_MAX) || seg_changed);
        dec_p1 = decode_seg(seg_p1[6:0]);
        sel_p1 = seg_p1[7];
    end

    // Stage p2: frame FSM, registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            msb_nib    <= 4'h0;
            tmo_cnt    <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            digit_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            digit_err  <= 1'b0;
            case (state)
                HUNT: begin
                    if (vld_p1) begin
                        if (!dec_p1[4]) begin
                            digit_err <= 1'b1;
                        end else if (!sel_p1) begin
                            msb_nib <= dec_p1[3:0];
                            tmo_cnt <= '0;
                            state   <= GOT_MSB;
                        end
                    end
                end
                GOT_MSB: begin
                    if (vld_p1) begin
                        if (!dec_p1[4]) begin
                            digit_err <= 1'b1;
                            state     <= HUNT;
                        end else if (!sel_p1) begin
                            msb_nib <= dec_p1[3:0];
                            tmo_cnt <= '0;
                        end else begin
                            byte_out   <= {msb_nib, dec_p1[3:0]};
                            byte_valid <= 1'b1;
                            state      <= HUNT;
                        end
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        state <= HUNT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TCNT_W'(1);
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    assign rx_busy = (state == GOT_MSB);

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed scoreboard bench for seven_seg_rx; output pulses are matched against a queue of expected events.
module tb_seven_seg_rx;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 4096;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       digit_err;
    logic       rx_busy;

    int compared   = 0;
    int mismatched = 0;

    // Event encoding: {2'b01, byte} = byte_valid with byte_out, {2'b10, 8'h00} = digit_err
    logic [9:0] exp_q[$];

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       m_got;
    logic [3:0] m_msb;
    logic [7:0] m_byte;
    logic [7:0] last_w;

    seven_seg_rx #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .digit_err (digit_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_dec(input logic [7:0] w);
        logic [4:0] r;
        r = 5'h00;
        for (int i = 0; i < 16; i++) begin
            if ((~w[6:0]) == pat[i]) r = {1'b1, 4'(i)};
        end
`ifdef SEVEN_SEG_RX_BCD_ONLY_EN
        if (r[4] && r[3:0] > 4'd9) r = 5'h00;
`endif
        return r;
    endfunction

    task automatic model_accept(input logic [7:0] w);
        logic [4:0] d;
        d = model_dec(w);
        if (!d[4]) begin
            exp_q.push_back({2'b10, 8'h00});
            m_got = 1'b0;
        end else if (!w[7]) begin
            m_msb = d[3:0];
            m_got = 1'b1;
        end else if (m_got) begin
            m_byte = {m_msb, d[3:0]};
            exp_q.push_back({2'b01, m_byte});
            m_got = 1'b0;
        end
    endtask

    // Called at a falling edge; the word is presented for n rising edges.
    task automatic hold(input logic [7:0] w, input int n);
        seg_in = w;
        if (n >= STABLE && w != last_w) model_accept(w);
        last_w = w;
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_got  = 1'b0;
        m_msb  = 4'h0;
        m_byte = 8'h00;
        last_w = 8'h7F;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid && digit_err) check("both_pulses", 32'd1, 32'd0);
            if (byte_valid || digit_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {22'd0, byte_valid, digit_err, byte_out}, 32'h3FF);
                end else begin
                    check("pulse", byte_valid ? {22'd0, 2'b01, byte_out} : {22'd0, 2'b10, 8'h00},
                          {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        seg_in = 8'hFF;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_flags", {byte_valid, digit_err, rx_busy}, 3'b000);
        rst_n = 1'b1;

        // Idle blank word after reset is an accepted invalid word.
        hold(8'hFF, 12);
        check("idle_busy", rx_busy, 1'b0);

        // Basic byte with exact latency
        hold(8'h24, 10);
        check("basic_busy", rx_busy, 1'b1);
        seg_in = 8'h99;
        model_accept(8'h99);
        last_w = 8'h99;
        repeat (5) @(posedge clk);
        #1 check("lat_early", byte_valid, 1'b0);
        @(posedge clk);
        #1 check("lat_edge", byte_valid, 1'b1);
        check("basic_byte", byte_out, 8'h24);
        repeat (4) @(negedge clk);
        check("basic_busy_after", rx_busy, 1'b0);

        // Glitch rejection
        hold(8'h24, 10);
        hold(8'h99, 2);
        hold(8'hF8, 10);
        check("glitch_byte", byte_out, 8'h27);

        // Invalid LSB
        hold(8'h24, 10);
        hold(8'hFF, 10);
        check("invalid_byte_hold", byte_out, 8'h27);
        check("invalid_hunt", rx_busy, 1'b0);

        // Timeout
        hold(8'h24, 20);
        check("tmo_busy_early", rx_busy, 1'b1);
        hold(8'h24, TIMEOUT);
        check("tmo_busy_dropped", rx_busy, 1'b0);
        m_got = 1'b0;
        hold(8'h99, 10);
        check("tmo_no_byte", byte_out, 8'h27);

        // Hex digit A, then LSB 0
        hold(8'h08, 10);
        hold(8'hC0, 10);
`ifdef SEVEN_SEG_RX_BCD_ONLY_EN
        check("hex_byte", byte_out, 8'h27);
`else
        check("hex_byte", byte_out, 8'hA0);
`endif
        check("hex_model_byte", byte_out, m_byte);

        // Reset mid-frame
        hold(8'h24, 10);
        check("mid_busy", rx_busy, 1'b1);
        rst_n  = 1'b0;
        seg_in = 8'h99;
        #1;
        check("mid_rst_byte", byte_out, 8'h00);
        check("mid_rst_flags", {byte_valid, digit_err, rx_busy}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        hold(8'h99, 10);
        check("mid_lone_lsb", byte_out, 8'h00);
        check("mid_lone_busy", rx_busy, 1'b0);

        hold(8'hFF, 10);
        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
